bus_memory_responder: RTL and testbench

- Memory-side responder for the CPU external bus. Sits between the bus control/address/data outputs and the instruction ROM and data RAM.
- Decodes the three mutually exclusive strobes: instruction-ROM read, data-RAM read and data-RAM write.
- Holds the data RAM internally, sequences the external ROM read port, and inserts programmable wait states.
- Returns read data with a one-cycle ready pulse that the bus steers into MBR.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/bus_memory_responder_if.sv | 33 +++
 rtl/ram_sp_sync.sv | 25 ++
 rtl/bus_memory_responder.sv | 116 +++++++++++
 tb/tb_bus_memory_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external-bus memory responder:
// bus width defaults, FSM state encoding and the access-type enum.
package mem_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_ROMFETCH = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  typedef enum logic [1:0] {
    ROM_RD = 2'd0,
    RAM_RD = 2'd1,
    RAM_WR = 2'd2
  } access_e;

  // True when two or more bits of the vector are set.
  function automatic logic more_than_one(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/bus_memory_responder_if.sv
// Bus-side signal bundle between the CPU external bus (master) and the
// memory responder (slave), including the external ROM read port.
interface bus_memory_responder_if #(
  parameter int unsigned ADDR_W = mem_bus_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_bus_pkg::DEF_DATA_W
) ();

  logic              i_instr_rom_read;
  logic              i_data_ram_read;
  logic              i_data_ram_write;
  logic [ADDR_W-1:0] i_address_bus;
  logic [DATA_W-1:0] i_data_bus;
  logic              o_rom_en;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic [DATA_W-1:0] o_rdata;
  logic              o_ready;
  logic              o_busy;
  logic              o_err;

  modport slave (
    input  i_instr_rom_read, i_data_ram_read, i_data_ram_write,
    input  i_address_bus, i_data_bus, i_rom_data,
    output o_rom_en, o_rom_addr, o_rdata, o_ready, o_busy, o_err
  );

  modport master (
    output i_instr_rom_read, i_data_ram_read, i_data_ram_write,
    output i_address_bus, i_data_bus, i_rom_data,
    input  o_rom_en, o_rom_addr, o_rdata, o_ready, o_busy, o_err
  );

endinterface

// File: rtl/ram_sp_sync.sv
// Single-port data RAM: synchronous write, combinational (asynchronous) read.
module ram_sp_sync #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // NOTE: storage arrays get no reset branch; clearing them would turn the
  // array into flops and the contents are meant to survive a reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder: strobe edge detection, wait-state sequencing,
// external ROM fetch and the internal data RAM, with ready/err pulses.
module bus_memory_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 0
) (
  input logic                   i_clk,
  input logic                   i_rst,
  bus_memory_responder_if.slave bus
);

  logic [1:0]        state;
  logic [3:0]        cnt;
  access_e           acc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  logic [2:0]        strb;
  logic [2:0]        hist;
  logic [2:0]        rise;
  logic              reject;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Bit order: {write, ram read, rom read}.
  assign strb   = {bus.i_data_ram_write, bus.i_data_ram_read, bus.i_instr_rom_read};
  assign rise   = strb & ~hist;
  assign reject = more_than_one(rise) || ((strb & ~rise) != 3'b000);

  // NOTE: the write is gated by reset so that a reset landing on the RESP
  // edge aborts the commit rather than racing it.
  assign ram_we = (state == ST_RESP) && (acc == RAM_WR) && !i_rst;

  ram_sp_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      hist   <= 3'b000;
      cnt    <= 4'd0;
      acc    <= RAM_RD;
      addr_q <= '0;
      data_q <= '0;
      rdata  <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      hist  <= strb;
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise != 3'b000) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              state  <= ST_WAIT;
              busy   <= 1'b1;
              addr_q <= bus.i_address_bus;
              data_q <= bus.i_data_bus;
              acc    <= rise[0] ? ROM_RD : (rise[1] ? RAM_RD : RAM_WR);
              cnt    <= rise[2] ? 4'(WR_WAIT) : 4'(RD_WAIT);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= (acc == ROM_RD) ? ST_ROMFETCH : ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ROMFETCH: begin
          rdata <= bus.i_rom_data;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (acc == RAM_RD) begin
            rdata <= ram_rdata;
          end
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The ROM is clocked on the last WAIT edge so its data is present in ROMFETCH.
  assign bus.o_rom_en   = (state == ST_WAIT) && (cnt == 4'd0) && (acc == ROM_RD);
  assign bus.o_rom_addr = addr_q;
  assign bus.o_rdata    = rdata;
  assign bus.o_ready    = ready;
  assign bus.o_busy     = busy;
  assign bus.o_err      = err;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench: two responders (WR_WAIT 0 and 3) driven by the same bus
// stimulus, each with its own synchronous ROM model.
module tb_bus_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rr = 1'b0, dr = 1'b0, dw = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rom0 = 16'h0000, rom1 = 16'h0000;

  always #5 clk = ~clk;

  bus_memory_responder_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
  bus_memory_responder_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

  assign bus0.i_instr_rom_read = rr;
  assign bus0.i_data_ram_read  = dr;
  assign bus0.i_data_ram_write = dw;
  assign bus0.i_address_bus    = addr;
  assign bus0.i_data_bus       = wdata;
  assign bus0.i_rom_data       = rom0;
  assign bus1.i_instr_rom_read = rr;
  assign bus1.i_data_ram_read  = dr;
  assign bus1.i_data_ram_write = dw;
  assign bus1.i_address_bus    = addr;
  assign bus1.i_data_bus       = wdata;
  assign bus1.i_rom_data       = rom1;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return (a == 8'h40) ? 16'hA5A5 : {a, 8'h3C};
  endfunction

  always @(posedge clk) if (bus0.o_rom_en) rom0 <= rom_word(bus0.o_rom_addr);
  always @(posedge clk) if (bus1.o_rom_en) rom1 <= rom_word(bus1.o_rom_addr);

  bus_memory_responder #(.ADDR_W(8), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(0)) dut0 (
    .i_clk (clk), .i_rst (rst), .bus (bus0)
  );
  bus_memory_responder #(.ADDR_W(8), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(3)) dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-DUT observations over one access window.
  int          first_rdy [2];
  int          n_rdy     [2];
  int          n_err     [2];
  int          n_romen   [2];
  int          n_busy    [2];
  logic [15:0] rd_last   [2];
  logic [7:0]  ra_last   [2];

  task automatic sample(input int d, input int c, input logic rdy, input logic er,
                        input logic bsy, input logic ren, input logic [7:0] ra,
                        input logic [15:0] rd);
    if (rdy) begin
      n_rdy[d]++;
      if (first_rdy[d] < 0) first_rdy[d] = c;
      rd_last[d] = rd;
    end
    if (er)  n_err[d]++;
    if (bsy) n_busy[d]++;
    if (ren) begin
      n_romen[d]++;
      ra_last[d] = ra;
    end
  endtask

  // Raises strb at the current negedge; cycle c is observed at the negedge after
  // posedge c. Strobes drop after cycle 'hold'; -1 disables the optional hooks.
  task automatic access(input logic [2:0] strb, input logic [7:0] a, input logic [15:0] wd,
                        input int hold, input int ncyc, input int extra_at,
                        input int rst_at, input int scramble_at);
    for (int d = 0; d < 2; d++) begin
      first_rdy[d] = -1; n_rdy[d] = 0; n_err[d] = 0; n_romen[d] = 0; n_busy[d] = 0;
      rd_last[d] = 16'h0; ra_last[d] = 8'h0;
    end
    {dw, dr, rr} = strb;
    addr  = a;
    wdata = wd;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      sample(0, c, bus0.o_ready, bus0.o_err, bus0.o_busy, bus0.o_rom_en, bus0.o_rom_addr, bus0.o_rdata);
      sample(1, c, bus1.o_ready, bus1.o_err, bus1.o_busy, bus1.o_rom_en, bus1.o_rom_addr, bus1.o_rdata);
      if (c == scramble_at) begin
        addr  = ~a;
        wdata = 16'hDEAD;
      end
      if (c == extra_at) dw = 1'b1;
      if (c == hold) begin
        {dw, dr, rr} = 3'b000;
        addr  = 8'h00;
        wdata = 16'h0000;
      end
      if (c == rst_at) rst = 1'b1;
      else if (c == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic ram_read_expect(input string tag, input logic [7:0] a, input logic [15:0] exp);
    access(3'b010, a, 16'h0, 0, 8, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_lat_d%0d", tag, d), first_rdy[d], 3);
      check($sformatf("%s_data_d%0d", tag, d), rd_last[d], exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_d0", bus0.o_ready, 0);   check("rst_ready_d1", bus1.o_ready, 0);
    check("rst_busy_d0", bus0.o_busy, 0);     check("rst_busy_d1", bus1.o_busy, 0);
    check("rst_err_d0", bus0.o_err, 0);       check("rst_err_d1", bus1.o_err, 0);
    check("rst_romen_d0", bus0.o_rom_en, 0);  check("rst_romen_d1", bus1.o_rom_en, 0);
    check("rst_rdata_d0", bus0.o_rdata, 0);   check("rst_rdata_d1", bus1.o_rdata, 0);
    check("rst_romaddr_d0", bus0.o_rom_addr, 0);
    check("rst_romaddr_d1", bus1.o_rom_addr, 0);
    rst = 1'b0;

    // RAM write: latency 2 + WR_WAIT, single ready, rdata untouched.
    access(3'b100, 8'h12, 16'hBEEF, 1, 8, -1, -1, -1);
    check("wr_lat_d0", first_rdy[0], 2);
    check("wr_lat_d1", first_rdy[1], 5);
    check("wr_nrdy_d0", n_rdy[0], 1);
    check("wr_nrdy_d1", n_rdy[1], 1);
    check("wr_rdata_kept_d0", bus0.o_rdata, 0);
    ram_read_expect("rd12", 8'h12, 16'hBEEF);

    // ROM read: one rom_en pulse at the latched address, latency 3 + RD_WAIT.
    access(3'b001, 8'h40, 16'h0, 1, 8, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rom_lat_d%0d", d), first_rdy[d], 4);
      check($sformatf("rom_en_cnt_d%0d", d), n_romen[d], 1);
      check($sformatf("rom_addr_d%0d", d), ra_last[d], 8'h40);
      check($sformatf("rom_data_d%0d", d), rd_last[d], 16'hA5A5);
    end

    // Held read strobe: one access; a write rising while it is held is rejected.
    access(3'b010, 8'h01, 16'h0, 10, 14, 6, -1, -1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("held_nrdy_d%0d", d), n_rdy[d], 1);
      check($sformatf("held_err_d%0d", d), n_err[d], 1);
    end

    // Same-cycle ROM read + RAM write: one err pulse, no access.
    access(3'b101, 8'h12, 16'h1111, 1, 8, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("conf_err_d%0d", d), n_err[d], 1);
      check($sformatf("conf_busy_d%0d", d), n_busy[d], 0);
      check($sformatf("conf_nrdy_d%0d", d), n_rdy[d], 0);
    end
    ram_read_expect("conf_rd12", 8'h12, 16'hBEEF);

    // Reset sampled on the third edge of a write aborts it in both configurations.
    access(3'b100, 8'h05, 16'h0BAD, 0, 8, -1, -1, -1);
    access(3'b100, 8'h05, 16'h1234, 0, 8, -1, 1, -1);
    for (int d = 0; d < 2; d++) check($sformatf("rstw_nrdy_d%0d", d), n_rdy[d], 0);
    check("rstw_rdata_d0", bus0.o_rdata, 0);
    check("rstw_rdata_d1", bus1.o_rdata, 0);
    ram_read_expect("rstw_rd05", 8'h05, 16'h0BAD);

    // Address/data latched at acceptance; top word 0xFF independent of 0x00.
    access(3'b100, 8'h00, 16'h0A0A, 0, 8, -1, -1, -1);
    access(3'b100, 8'hFF, 16'h7777, 3, 8, -1, -1, 0);
    ram_read_expect("wrap_rdFF", 8'hFF, 16'h7777);
    ram_read_expect("wrap_rd00", 8'h00, 16'h0A0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
